// File: rtl/shift_reg_seq_pkg.sv
// shift_reg_seq_pkg: command, select and state encodings plus the shared shift rule
package shift_reg_seq_pkg;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_SHR = 2'b01, OP_SHL = 2'b10, OP_ROT = 2'b11} op_t;
  typedef enum logic [1:0] {SEL_HOLD = 2'b00, SEL_SHR = 2'b01, SEL_SHL = 2'b10, SEL_LOAD = 2'b11} sel_t;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_EXEC = 2'b01, S_CHECK = 2'b10} state_t;

  function automatic sel_t sel_of(op_t op, logic fill);
    return op == OP_LOAD ? SEL_LOAD :
           op == OP_SHR  ? SEL_SHR  :
           op == OP_SHL  ? SEL_SHL  :
           fill          ? SEL_SHL  : SEL_SHR;
  endfunction

  // ROT draws its wrap bit from the value itself, matching the register's feedback path
  function automatic logic [3:0] step_val(op_t op, logic fill, logic [3:0] d, logic [3:0] v);
    return op == OP_LOAD ? d :
           op == OP_SHR  ? {fill, v[3:1]} :
           op == OP_SHL  ? {v[2:0], fill} :
           fill          ? {v[2:0], v[3]} : {v[0], v[3:1]};
  endfunction
endpackage

// File: rtl/shift_reg_seq.sv
// shift_reg_seq: sequences LOAD/SHR/SHL/ROT commands into a 4-bit universal shift register
module shift_reg_seq
  import shift_reg_seq_pkg::*;
#(
  parameter int COUNT_W  = 3,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [3:0]         cmd_data,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic               cmd_fill,
  input  logic               p_out3,
  input  logic               p_out2,
  input  logic               p_out1,
  input  logic               p_out0,
  output logic               select1,
  output logic               select0,
  output logic               p_in3,
  output logic               p_in2,
  output logic               p_in1,
  output logic               p_in0,
  output logic               right_shift_inp,
  output logic               left_shift_inp,
  output logic               busy,
  output logic               done,
  output logic               err
);
  state_t               state;
  op_t                  op_q;
  logic [3:0]           data_q;
  logic [3:0]           shadow;
  logic                 fill_q;
  logic [COUNT_W-1:0]   cnt;
  logic                 exec;
  logic [3:0]           p_out;

  assign p_out = {p_out3, p_out2, p_out1, p_out0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_LOAD;
      data_q <= '0;
      fill_q <= 1'b0;
      cnt    <= '0;
      shadow <= '0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          op_q   <= op_t'(cmd_op);
          data_q <= cmd_data;
          fill_q <= cmd_fill;
          cnt    <= cmd_count;
          state  <= (op_t'(cmd_op) != OP_LOAD && cmd_count == '0) ? S_CHECK : S_EXEC;
        end
        S_EXEC: begin
          shadow <= step_val(op_q, fill_q, data_q, shadow);
          cnt    <= op_q == OP_LOAD ? '0 : cnt - 1'b1;
          state  <= (op_q == OP_LOAD || cnt == COUNT_W'(1)) ? S_CHECK : S_EXEC;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    exec      = state == S_EXEC;
    cmd_ready = state == S_IDLE;
    busy      = ~cmd_ready;
    done      = state == S_CHECK;
    err       = CHECK_EN & done & (p_out != shadow);
    {select1, select0}         = exec ? sel_of(op_q, fill_q) : SEL_HOLD;
    {p_in3, p_in2, p_in1, p_in0} = (exec && op_q == OP_LOAD) ? data_q : 4'b0;
    right_shift_inp = exec & ((op_q == OP_SHR & fill_q) | (op_q == OP_ROT & ~fill_q & p_out0));
    left_shift_inp  = exec & ((op_q == OP_SHL & fill_q) | (op_q == OP_ROT & fill_q & p_out3));
  end
endmodule

// File: tb/tb_shift_reg_seq.sv
// tb_shift_reg_seq: directed and random commands against an arithmetic reference model
module tb_shift_reg_seq;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_fill = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_data = '0;
  logic [2:0] cmd_count = '0;
  logic p_out3, p_out2, p_out1, p_out0, select1, select0, p_in3, p_in2, p_in1, p_in0;
  logic right_shift_inp, left_shift_inp, cmd_ready, busy, done, err;
  logic [3:0] q, model;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  shift_reg_seq dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
    .p_out3(p_out3), .p_out2(p_out2), .p_out1(p_out1), .p_out0(p_out0),
    .select1(select1), .select0(select0), .p_in3(p_in3), .p_in2(p_in2), .p_in1(p_in1), .p_in0(p_in0),
    .right_shift_inp(right_shift_inp), .left_shift_inp(left_shift_inp),
    .busy(busy), .done(done), .err(err)
  );

  // downstream universal shift register; deliberately has no reset
  assign {p_out3, p_out2, p_out1, p_out0} = q;
  always @(posedge clk)
    case ({select1, select0})
      2'b01: q <= {right_shift_inp, q[3:1]};
      2'b10: q <= {q[2:0], left_shift_inp};
      2'b11: q <= {p_in3, p_in2, p_in1, p_in0};
      default: q <= q;
    endcase

  function automatic logic [3:0] ref_cmd(int op, logic [3:0] d, int n, logic fill, logic [3:0] v);
    int x;
    x = v;
    if (op == 0) return d;
    for (int i = 0; i < n; i++)
      x = op == 1 ? fill * 8 + x / 2 :
          op == 2 ? (x * 2 + fill) % 16 :
          fill    ? (x * 2) % 16 + x / 8 : (x % 2) * 8 + x / 2;
    return x[3:0];
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(int op, logic [3:0] d, int n, logic fill);
    cmd_op = op[1:0]; cmd_data = d; cmd_count = n[2:0]; cmd_fill = fill; cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !cmd_ready; i++) step;
    chk("ready_wait", cmd_ready, 1);
    step;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      step;
      lat++;
    end
  endtask

  task automatic run(string tag, int op, logic [3:0] d, int n, logic fill);
    int lat;
    issue(op, d, n, fill);
    wait_done(lat);
    model = ref_cmd(op, d, n, fill, model);
    chk({tag, "_lat"}, lat, op == 0 ? 1 : n);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_pout"}, q, model);
    step;
  endtask

  initial begin
    int n;
    step; step;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sel", {select1, select0}, 0);
    chk("rst_pin", {p_in3, p_in2, p_in1, p_in0}, 0);
    chk("rst_serial", {right_shift_inp, left_shift_inp}, 0);
    rst = 1'b0;
    step;
    issue(0, 4'b1011, 0, 0);
    chk("t1_sel", {select1, select0}, 3);
    chk("t1_pin", {p_in3, p_in2, p_in1, p_in0}, 4'b1011);
    chk("t1_busy", busy, 1);
    step;
    chk("t1_done", done, 1);
    chk("t1_err", err, 0);
    chk("t1_pout", q, 4'b1011);
    chk("t1_sel_check", {select1, select0}, 0);
    step;
    chk("t1_ready", cmd_ready, 1);
    model = 4'b1011;
    issue(1, 4'b0000, 2, 0);
    chk("t2_sel", {select1, select0}, 1);
    step;
    chk("t2_first", q, 4'b0101);
    step;
    chk("t2_second", q, 4'b0010);
    chk("t2_done", done, 1);
    chk("t2_err", err, 0);
    step;
    run("t3_load", 0, 4'b1001, 0, 0);
    run("t3_rotl", 3, 4'b0000, 1, 1);
    chk("t3_rotl_val", q, 4'b0011);
    run("t3_load2", 0, 4'b1001, 0, 0);
    issue(3, 4'b0000, 5, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t3_rsi_track", right_shift_inp, q[0]);
      chk("t3_rotr_sel", {select1, select0}, 1);
      step;
    end
    chk("t3_rotr_done", done, 1);
    chk("t3_rotr_val", q, 4'b1100);
    step;
    run("t4_load", 0, 4'b0110, 0, 0);
    issue(2, 4'b0000, 0, 1);
    chk("t4_sel", {select1, select0}, 0);
    chk("t4_done", done, 1);
    chk("t4_pout", q, 4'b0110);
    chk("t4_lsi", left_shift_inp, 0);
    step;
    issue(0, 4'b1111, 0, 0);
    cmd_op = 2'b10; cmd_data = 4'b0000; cmd_count = 3'd2; cmd_fill = 1'b0; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      step;
      n++;
    end
    chk("t5_gap", n, 2);
    step;
    cmd_valid = 1'b0;
    wait_done(n);
    chk("t5_lat", n, 2);
    chk("t5_val", q, 4'b1100);
    chk("t5_err", err, 0);
    step;
    run("t6_load", 0, 4'b1111, 0, 0);
    issue(1, 4'b0000, 7, 0);
    step; step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("t6_sel", {select1, select0}, 0);
    chk("t6_ready", cmd_ready, 1);
    chk("t6_pout", q, 4'b0001);
    issue(1, 4'b0000, 0, 0);
    chk("t6_done", done, 1);
    chk("t6_err", err, 1);
    chk("t6_hold", q, 4'b0001);
    step;
    model = 4'($urandom_range(0, 15));
    run("rnd_load", 0, model, 0, 0);
    for (int i = 0; i < 40; i++)
      run("rnd", int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
